// File: rtl/exu_ir_skid_if.sv
// IFU-to-EXU IR-stage handshake bundle: the IFU payload channel and the decoder-facing channel.
// The skid buffer attaches through the slave modport; the surrounding pipeline (or a bench) uses master.
interface exu_ir_skid_if #(
  parameter int PC_W    = 32,
  parameter int IR_W    = 32,
  parameter int RFIDX_W = 5
);
  logic               ifu_o_valid;
  logic               ifu_o_ready;
  logic [IR_W-1:0]    ifu_o_ir;
  logic [PC_W-1:0]    ifu_o_pc;
  logic               ifu_o_pc_vld;
  logic               ifu_o_misalgn;
  logic               ifu_o_buserr;
  logic [RFIDX_W-1:0] ifu_o_rs1idx;
  logic [RFIDX_W-1:0] ifu_o_rs2idx;
  logic               ifu_o_prdt_taken;
  logic               ifu_o_muldiv_b2b;

  logic               dec_i_valid;
  logic               dec_i_ready;
  logic [IR_W-1:0]    dec_i_ir;
  logic [PC_W-1:0]    dec_i_pc;
  logic               dec_i_pc_vld;
  logic               dec_i_misalgn;
  logic               dec_i_buserr;
  logic [RFIDX_W-1:0] dec_i_rs1idx;
  logic [RFIDX_W-1:0] dec_i_rs2idx;
  logic               dec_i_prdt_taken;
  logic               dec_i_muldiv_b2b;

  modport slave (
    input  ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_pc_vld, ifu_o_misalgn, ifu_o_buserr,
           ifu_o_rs1idx, ifu_o_rs2idx, ifu_o_prdt_taken, ifu_o_muldiv_b2b,
    output ifu_o_ready,
    output dec_i_valid, dec_i_ir, dec_i_pc, dec_i_pc_vld, dec_i_misalgn, dec_i_buserr,
           dec_i_rs1idx, dec_i_rs2idx, dec_i_prdt_taken, dec_i_muldiv_b2b,
    input  dec_i_ready
  );

  modport master (
    output ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_pc_vld, ifu_o_misalgn, ifu_o_buserr,
           ifu_o_rs1idx, ifu_o_rs2idx, ifu_o_prdt_taken, ifu_o_muldiv_b2b,
    input  ifu_o_ready,
    input  dec_i_valid, dec_i_ir, dec_i_pc, dec_i_pc_vld, dec_i_misalgn, dec_i_buserr,
           dec_i_rs1idx, dec_i_rs2idx, dec_i_prdt_taken, dec_i_muldiv_b2b,
    output dec_i_ready
  );
endinterface

// File: rtl/exu_ir_skid.sv
// EXU-side IR-stage receiver: small registered FIFO between IFU and decoder, plus flush/halt handling.
// Optional per-entry even parity with sticky error flag when E203_IR_SKID_PARITY_EN is defined.
module exu_ir_skid #(
  parameter int PC_W    = 32,
  parameter int IR_W    = 32,
  parameter int RFIDX_W = 5,
  parameter int DEPTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  exu_ir_skid_if.slave                 bus,
  input  logic                         pipe_flush_req,
  output logic                         pipe_flush_ack,
  input  logic                         ifu_halt_req,
  output logic                         ifu_halt_ack,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef E203_IR_SKID_PARITY_EN
  ,
  input  logic                         par_inject,
  output logic                         par_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PAY_W = IR_W + PC_W + 2 * RFIDX_W + 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  function automatic logic even_par(input logic [PAY_W-1:0] d);
    return ^d;
  endfunction

  state_e             state_r;
  logic               rdy_en_r;
  logic               flush_ack_r;
  logic               halt_ack_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [PAY_W-1:0]   mem_r [DEPTH];

  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [PAY_W-1:0]   wr_pay_s;
  logic [PAY_W-1:0]   rd_pay_s;

  assign full_s  = (cnt_r == CNT_W'(DEPTH));
  assign empty_s = (cnt_r == {CNT_W{1'b0}});

  // rdy_en_r keeps ready low while reset is held and releases it on the first edge afterwards.
  assign bus.ifu_o_ready = rdy_en_r & ~full_s & ~pipe_flush_req & (state_r == ST_RUN);
  assign bus.dec_i_valid = ~empty_s & ~pipe_flush_req;

  assign push_s = bus.ifu_o_valid & bus.ifu_o_ready;
  assign pop_s  = bus.dec_i_valid & bus.dec_i_ready;

  assign wr_pay_s = {bus.ifu_o_ir, bus.ifu_o_pc, bus.ifu_o_pc_vld, bus.ifu_o_misalgn,
                     bus.ifu_o_buserr, bus.ifu_o_rs1idx, bus.ifu_o_rs2idx,
                     bus.ifu_o_prdt_taken, bus.ifu_o_muldiv_b2b};
  assign rd_pay_s = mem_r[rd_ptr_r];

  assign {bus.dec_i_ir, bus.dec_i_pc, bus.dec_i_pc_vld, bus.dec_i_misalgn,
          bus.dec_i_buserr, bus.dec_i_rs1idx, bus.dec_i_rs2idx,
          bus.dec_i_prdt_taken, bus.dec_i_muldiv_b2b} = rd_pay_s;

  assign occupancy      = cnt_r;
  assign pipe_flush_ack = flush_ack_r;
  assign ifu_halt_ack   = halt_ack_r;

  // FIFO storage, pointers, occupancy and flush acknowledge; flush overrides push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {PAY_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      flush_ack_r <= 1'b0;
      rdy_en_r    <= 1'b0;
    end else begin
      rdy_en_r    <= 1'b1;
      flush_ack_r <= pipe_flush_req;
      if (pipe_flush_req) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          mem_r[wr_ptr_r] <= wr_pay_s;
          wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
      end
    end
  end

  // Halt FSM; the ack is registered alongside the state so it rises on entry to HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      halt_ack_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          halt_ack_r <= 1'b0;
          if (ifu_halt_req) begin
            state_r <= ST_HALTING;
          end
        end
        ST_HALTING: begin
          if (!ifu_halt_req) begin
            state_r    <= ST_RUN;
            halt_ack_r <= 1'b0;
          end else if (empty_s) begin
            state_r    <= ST_HALTED;
            halt_ack_r <= 1'b1;
          end else begin
            halt_ack_r <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (!ifu_halt_req) begin
            state_r    <= ST_RUN;
            halt_ack_r <= 1'b0;
          end else begin
            halt_ack_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          halt_ack_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef E203_IR_SKID_PARITY_EN
  logic par_mem_r [DEPTH];
  logic par_err_r;

  assign par_err = par_err_r;

  // Parity bit captured per entry at push; checked on pop into a sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_mem_r[i] <= 1'b0;
      end
      par_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        par_mem_r[wr_ptr_r] <= even_par(wr_pay_s) ^ par_inject;
      end
      par_err_r <= par_err_r | (pop_s & (even_par(rd_pay_s) != par_mem_r[rd_ptr_r]));
    end
  end
`endif

endmodule

// File: tb/tb_exu_ir_skid.sv
// Directed self-checking bench for exu_ir_skid: streaming, backpressure, flush, halt, reset, parity.
module tb_exu_ir_skid;
  localparam int PC_W    = 32;
  localparam int IR_W    = 32;
  localparam int RFIDX_W = 5;
  localparam int DEPTH   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pipe_flush_req;
  logic       pipe_flush_ack;
  logic       ifu_halt_req;
  logic       ifu_halt_ack;
  logic [1:0] occupancy;
`ifdef E203_IR_SKID_PARITY_EN
  logic       par_inject;
  logic       par_err;
`endif

  int nchk = 0;
  int nerr = 0;

  exu_ir_skid_if #(.PC_W(PC_W), .IR_W(IR_W), .RFIDX_W(RFIDX_W)) bus ();

  exu_ir_skid #(.PC_W(PC_W), .IR_W(IR_W), .RFIDX_W(RFIDX_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .pipe_flush_req (pipe_flush_req),
    .pipe_flush_ack (pipe_flush_ack),
    .ifu_halt_req   (ifu_halt_req),
    .ifu_halt_ack   (ifu_halt_ack),
    .occupancy      (occupancy)
`ifdef E203_IR_SKID_PARITY_EN
    ,
    .par_inject     (par_inject),
    .par_err        (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic rdy);
    bus.ifu_o_valid = v;
    bus.ifu_o_ir    = ir;
    bus.ifu_o_pc    = pc;
    bus.dec_i_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                  = 1'b1;
    pipe_flush_req       = 1'b0;
    ifu_halt_req         = 1'b0;
    bus.ifu_o_pc_vld     = 1'b0;
    bus.ifu_o_misalgn    = 1'b0;
    bus.ifu_o_buserr     = 1'b0;
    bus.ifu_o_rs1idx     = 5'd0;
    bus.ifu_o_rs2idx     = 5'd0;
    bus.ifu_o_prdt_taken = 1'b0;
    bus.ifu_o_muldiv_b2b = 1'b0;
`ifdef E203_IR_SKID_PARITY_EN
    par_inject = 1'b0;
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst_dec_valid", bus.dec_i_valid, 1'b0);
    chk("rst_dec_ir", bus.dec_i_ir, 32'h0);
    chk("rst_ifu_ready", bus.ifu_o_ready, 1'b0);
    chk("rst_flush_ack", pipe_flush_ack, 1'b0);
    chk("rst_halt_ack", ifu_halt_ack, 1'b0);
    chk("rst_occ", occupancy, 2'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", bus.ifu_o_ready, 1'b1);

    // streaming: one beat per cycle with the decoder always ready
    for (int n = 0; n < 6; n++) begin
      drive(1'b1, 32'h0000_0013 + 32'(n), 32'h8000_0000 + 32'(4 * n), 1'b1);
      bus.ifu_o_rs1idx = 5'(n);
      tick();
      chk("stream_valid", bus.dec_i_valid, 1'b1);
      chk("stream_ir", bus.dec_i_ir, 32'h0000_0013 + 32'(n));
      chk("stream_pc", bus.dec_i_pc, 32'h8000_0000 + 32'(4 * n));
      chk("stream_rs1", bus.dec_i_rs1idx, 5'(n));
      chk("stream_occ", occupancy, 2'd1);
      chk("stream_ready", bus.ifu_o_ready, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("stream_drain_occ", occupancy, 2'd0);
    chk("stream_drain_valid", bus.dec_i_valid, 1'b0);

    // backpressure: third beat must be held off until a pop frees an entry
    drive(1'b1, 32'hA000_0000, 32'h100, 1'b0);
    tick();
    chk("bp_occ1", occupancy, 2'd1);
    chk("bp_ready1", bus.ifu_o_ready, 1'b1);
    drive(1'b1, 32'hA000_0001, 32'h104, 1'b0);
    tick();
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_ready_full", bus.ifu_o_ready, 1'b0);
    chk("bp_head_a0", bus.dec_i_ir, 32'hA000_0000);
    drive(1'b1, 32'hA000_0002, 32'h108, 1'b0);
    tick();
    chk("bp_occ_hold", occupancy, 2'd2);
    chk("bp_ready_hold", bus.ifu_o_ready, 1'b0);
    drive(1'b1, 32'hA000_0002, 32'h108, 1'b1);
    tick();
    chk("bp_pop_occ", occupancy, 2'd1);
    chk("bp_head_a1", bus.dec_i_ir, 32'hA000_0001);
    chk("bp_ready_again", bus.ifu_o_ready, 1'b1);
    tick();
    chk("bp_head_a2", bus.dec_i_ir, 32'hA000_0002);
    chk("bp_occ_pp", occupancy, 2'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("bp_empty", occupancy, 2'd0);

    // flush with a concurrent beat that must not be stored
    drive(1'b1, 32'hB000_0000, 32'h200, 1'b0);
    tick();
    drive(1'b1, 32'hB000_0001, 32'h204, 1'b0);
    tick();
    chk("fl_occ_pre", occupancy, 2'd2);
    pipe_flush_req = 1'b1;
    drive(1'b1, 32'hB000_0002, 32'h208, 1'b0);
    #1;
    chk("fl_valid_gated", bus.dec_i_valid, 1'b0);
    chk("fl_ready_gated", bus.ifu_o_ready, 1'b0);
    tick();
    pipe_flush_req = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("fl_occ0", occupancy, 2'd0);
    chk("fl_ack1", pipe_flush_ack, 1'b1);
    tick();
    chk("fl_ack_pulse", pipe_flush_ack, 1'b0);
    chk("fl_occ_stay", occupancy, 2'd0);
    chk("fl_valid0", bus.dec_i_valid, 1'b0);
    drive(1'b1, 32'hC000_0000, 32'h300, 1'b0);
    tick();
    chk("fl_after_ir", bus.dec_i_ir, 32'hC000_0000);
    chk("fl_after_occ", occupancy, 2'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("fl_after_drain", occupancy, 2'd0);

    // halt with two buffered entries: pops continue, pushes blocked
    drive(1'b1, 32'hD000_0000, 32'h400, 1'b0);
    tick();
    drive(1'b1, 32'hD000_0001, 32'h404, 1'b0);
    tick();
    chk("h_occ_pre", occupancy, 2'd2);
    ifu_halt_req = 1'b1;
    drive(1'b1, 32'hD000_0002, 32'h408, 1'b1);
    tick();
    chk("h_ready_blk", bus.ifu_o_ready, 1'b0);
    chk("h_occ1", occupancy, 2'd1);
    chk("h_head_d1", bus.dec_i_ir, 32'hD000_0001);
    chk("h_ack_early", ifu_halt_ack, 1'b0);
    tick();
    chk("h_occ0", occupancy, 2'd0);
    chk("h_ack_empty", ifu_halt_ack, 1'b0);
    chk("h_ready_blk2", bus.ifu_o_ready, 1'b0);
    tick();
    chk("h_ack1", ifu_halt_ack, 1'b1);
    chk("h_no_push", occupancy, 2'd0);
    chk("h_ready_halted", bus.ifu_o_ready, 1'b0);
    tick();
    chk("h_ack_hold", ifu_halt_ack, 1'b1);
    ifu_halt_req = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("h_ack_drop", ifu_halt_ack, 1'b0);
    chk("h_ready_back", bus.ifu_o_ready, 1'b1);

    // halt requested while already empty still spends one cycle in HALTING
    ifu_halt_req = 1'b1;
    tick();
    chk("he_ack0", ifu_halt_ack, 1'b0);
    tick();
    chk("he_ack1", ifu_halt_ack, 1'b1);
    ifu_halt_req = 1'b0;
    tick();
    chk("he_ack_drop", ifu_halt_ack, 1'b0);

    // reset mid-operation, coincident with a flush request
    drive(1'b1, 32'hE000_0000, 32'h500, 1'b0);
    tick();
    chk("rm_valid_pre", bus.dec_i_valid, 1'b1);
    chk("rm_occ_pre", occupancy, 2'd1);
    rst            = 1'b1;
    pipe_flush_req = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    pipe_flush_req = 1'b0;
    #1;
    chk("rm_valid", bus.dec_i_valid, 1'b0);
    chk("rm_ir", bus.dec_i_ir, 32'h0);
    chk("rm_pc", bus.dec_i_pc, 32'h0);
    chk("rm_occ", occupancy, 2'd0);
    chk("rm_flush_ack", pipe_flush_ack, 1'b0);
    chk("rm_halt_ack", ifu_halt_ack, 1'b0);
    chk("rm_ready", bus.ifu_o_ready, 1'b0);
    rst = 1'b0;
    tick();
    chk("rm_ready_back", bus.ifu_o_ready, 1'b1);

`ifdef E203_IR_SKID_PARITY_EN
    drive(1'b1, 32'hF000_0000, 32'h600, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("par_clean", par_err, 1'b0);
    par_inject = 1'b1;
    drive(1'b1, 32'hF000_0001, 32'h604, 1'b0);
    tick();
    par_inject = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    chk("par_pre_pop", par_err, 1'b0);
    tick();
    chk("par_set", par_err, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("par_sticky", par_err, 1'b1);
    rst = 1'b1;
    tick();
    chk("par_rst_clr", par_err, 1'b0);
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
